// File: rtl/inst_fetch_unit_pkg.sv
// Core-wide fetch definitions: reset vector, NOP encoding, fault causes and the
// fetch buffer entry layout shared by the fetch unit and its buffer.
package inst_fetch_unit_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_e;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    fault_e            fault;
  } fetch_entry_t;

  // Misalignment wins over range; last_ok is the highest legal word address.
  function automatic fault_e pc_fault(input logic [31:0] pc, input logic [31:0] last_ok);
    if (pc[1:0] != 2'b00) begin
      return FAULT_MISALIGN;
    end else if (pc > last_ok) begin
      return FAULT_RANGE;
    end else begin
      return FAULT_NONE;
    end
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Small elastic fetch buffer: flushable FIFO that accepts a push while full as
// long as the head is popped in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Payload needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per cycle from a
// zero-latency instruction memory and hands {pc, inst, fault} to decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_BYTES = 1024,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  if_fault
);

  localparam logic [31:0] LAST_OK_PC = 32'(MEM_BYTES - 4);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  mode_e        mode_q;
  mode_e        mode_d;
  fault_e       cur_fault;
  logic         pop;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic         fifo_full;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [$bits(fetch_entry_t)-1:0] head_bits;

  assign imem_addr = pc_q;
  assign cur_fault = pc_fault(pc_q, LAST_OK_PC);
  assign pop       = if_valid & if_ready;
  assign fifo_pop  = pop & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      mode_q <= MODE_RUN;
    end else begin
      pc_q   <= pc_d;
      mode_q <= mode_d;
    end
  end

  // A faulting fetch still occupies a slot (carrying a NOP) so decode sees the cause.
  always_comb begin
    pc_d       = pc_q;
    mode_d     = mode_q;
    fifo_push  = 1'b0;
    push_entry = '{pc: pc_q, inst: imem_data, fault: cur_fault};
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      mode_d = MODE_RUN;
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (!fifo_full || pop) begin
            fifo_push = 1'b1;
            if (cur_fault == FAULT_NONE) begin
              pc_d = pc_q + 32'd4;
            end else begin
              push_entry.inst = NOP_INST;
              mode_d          = MODE_HALT;
            end
          end
        end
        MODE_HALT: begin
          mode_d = MODE_HALT;
        end
        default: begin
          mode_d = MODE_RUN;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .head_data(head_bits)
  );

  assign head_entry = head_bits;
  assign if_valid   = ~fifo_empty;
  assign if_pc      = if_valid ? head_entry.pc    : 32'd0;
  assign if_inst    = if_valid ? head_entry.inst  : 32'd0;
  assign if_fault   = if_valid ? head_entry.fault : 2'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus random stimulus, all
// compared against a queue-based model of the fetch front end.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  if_fault;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(1024),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_fault      (if_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  fault;
  } ent_t;

  logic [31:0] memArr [256];
  ent_t        modelQ [$];
  logic [31:0] modelPc;
  bit          modelHalt;
  bit          modelKnown;
  int          vectorCount;
  int          missCount;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr[1:0] == 2'b00 && addr < 32'd1024) begin
      return memArr[addr[9:2]];
    end
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_data = memWord(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Outputs as they should look given the model's current buffer and PC.
  task automatic checkAgainstModel();
    checkOutput("imem_addr", imem_addr, modelPc);
    if (modelQ.size() > 0) begin
      checkOutput("if_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("if_pc", if_pc, modelQ[0].pc);
      checkOutput("if_inst", if_inst, modelQ[0].inst);
      checkOutput("if_fault", {30'd0, if_fault}, {30'd0, modelQ[0].fault});
    end else begin
      checkOutput("if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("if_pc_idle", if_pc, 32'd0);
      checkOutput("if_inst_idle", if_inst, 32'd0);
      checkOutput("if_fault_idle", {30'd0, if_fault}, 32'd0);
    end
  endtask

  task automatic stepModel(input bit rstN, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit   doPop;
    bit   doPush;
    ent_t e;
    if (!rstN) begin
      modelQ.delete();
      modelPc    = 32'h0;
      modelHalt  = 1'b0;
      modelKnown = 1'b1;
    end else if (rv) begin
      modelQ.delete();
      modelPc   = rpc;
      modelHalt = 1'b0;
    end else begin
      doPop  = (modelQ.size() > 0) && rdy;
      doPush = !modelHalt && ((modelQ.size() < DEPTH) || doPop);
      if (doPop) begin
        void'(modelQ.pop_front());
      end
      if (doPush) begin
        e.pc = modelPc;
        if (modelPc % 4 != 0) begin
          e.fault = 2'd1;
        end else if (modelPc > 32'd1020) begin
          e.fault = 2'd2;
        end else begin
          e.fault = 2'd0;
        end
        if (e.fault == 2'd0) begin
          e.inst  = memWord(modelPc);
          modelPc = modelPc + 32'd4;
        end else begin
          e.inst    = 32'h0000_0013;
          modelHalt = 1'b1;
        end
        modelQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    reset          = rstN;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #1;
    if (modelKnown) begin
      checkAgainstModel();
    end
    stepModel(rstN, rv, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic expectHead(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] fault);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    checkOutput({tag, "_pc"}, if_pc, pc);
    checkOutput({tag, "_inst"}, if_inst, inst);
    checkOutput({tag, "_fault"}, {30'd0, if_fault}, {30'd0, fault});
  endtask

  task automatic expectEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    checkOutput({tag, "_pc"}, if_pc, 32'd0);
    checkOutput({tag, "_inst"}, if_inst, 32'd0);
    checkOutput({tag, "_fault"}, {30'd0, if_fault}, 32'd0);
  endtask

  initial begin
    logic [31:0] rpc;
    vectorCount    = 0;
    missCount      = 0;
    modelKnown     = 1'b0;
    modelHalt      = 1'b0;
    modelPc        = 32'h0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    for (int i = 0; i < 256; i++) begin
      memArr[i] = $urandom;
    end
    memArr[0] = 32'h00C0_0113;
    memArr[1] = 32'h0010_0193;

    $display("[TB] basic fetch after reset");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectEmpty("reset");
    checkOutput("reset_imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("cyc1", 32'd0, 32'h00C0_0113, 2'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("cyc2", 32'd4, 32'h0010_0193, 2'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    end
    checkOutput("stall_imem_addr", imem_addr, 32'd8);
    expectHead("stall_head", 32'd0, 32'h00C0_0113, 2'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("release1", 32'd4, 32'h0010_0193, 2'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("release2", 32'd8, memArr[2], 2'd0);

    $display("[TB] redirect while full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 32'd700, 1'b1);
    expectEmpty("redir_bubble");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("redir700", 32'd700, memArr[175], 2'd0);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 32'd702, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    expectHead("misalign", 32'd702, 32'h0000_0013, 2'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      expectEmpty("halted");
    end
    applyStimulus(1'b1, 1'b1, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("resume", 32'd0, 32'h00C0_0113, 2'd0);

    $display("[TB] end of memory");
    applyStimulus(1'b1, 1'b1, 32'd1016, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("pc1016", 32'd1016, memArr[254], 2'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("pc1020", 32'd1020, memArr[255], 2'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("range", 32'd1024, 32'h0000_0013, 2'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectEmpty("range_halt");
    checkOutput("range_imem_addr", imem_addr, 32'd1024);

    $display("[TB] reset beats redirect");
    applyStimulus(1'b1, 1'b1, 32'd64, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 32'd500, 1'b0);
    expectEmpty("rst_redir");
    checkOutput("rst_redir_imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    expectHead("rst_redir_restart", 32'd0, 32'h00C0_0113, 2'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        1:       rpc = 32'd1008 + 32'($urandom_range(0, 4) * 4);
        2:       rpc = 32'hFFFF_FFFC;
        default: rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 11) == 0),
                    rpc,
                    ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
